// File: rtl/result_streamer_pkg.sv
// result_streamer_pkg: shared sizing and FSM state type for the result
// streamer. WIDTH/MATRIX_SIZE/CHUNK_SIZE are the PIM datapath dimensions.
// NUM_EL is the element count of one product matrix. IDX_W is wide enough
// to carry index NUM_EL, which the optional checksum beat uses.
package result_streamer_pkg;
  localparam int WIDTH       = 32;
  localparam int MATRIX_SIZE = 8;
  localparam int CHUNK_SIZE  = 4;
  localparam int NUM_EL      = MATRIX_SIZE**2;
  localparam int IDX_W       = $clog2(NUM_EL+1);

  typedef enum logic [1:0] {IDLE, STREAM, CKSUM} streamer_state_t;
endpackage

// File: rtl/result_streamer_if.sv
// result_streamer_if: valid/ready output stream of the result streamer.
//   out_data  - current element
//   out_valid - data/index/last valid
//   out_ready - consumer accepts the beat
//   out_last  - final beat of a matrix
//   out_index - row-major source index of the beat
// The master modport is the streamer and the slave modport is the consumer.
interface result_streamer_if;
  import result_streamer_pkg::*;

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IDX_W-1:0] out_index;

  modport master (output out_data, out_valid, out_last, out_index, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_index, output out_ready);
endinterface

// File: rtl/result_streamer.sv
// result_streamer: captures a product matrix on a one-cycle result_ready
// pulse and drains it one element per accepted beat. The drain order is
// row-major (COL_MAJOR=0) or column-major (COL_MAJOR=1).
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   result         - NUM_EL elements, row-major
//   result_ready   - pulse: result valid this cycle
//   clear_overflow - clears the sticky overflow flag
//   busy           - high while not IDLE
//   overflow       - sticky: a result pulse was dropped while busy
//   m_out          - output stream (result_streamer_if.master)
// Optional feature: define RESULT_STREAM_CHECKSUM_EN to append one beat
// after the matrix. That beat carries the XOR of all elements, with
// out_index = NUM_EL and out_last set.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int COL_MAJOR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     result [NUM_EL],
  input  logic                 result_ready,
  input  logic                 clear_overflow,
  output logic                 busy,
  output logic                 overflow,
  result_streamer_if.master    m_out
);

  localparam int                 AW        = $clog2(NUM_EL);
  localparam logic [IDX_W-1:0]   LAST_BEAT = IDX_W'(NUM_EL-1);
  localparam logic [IDX_W-1:0]   MS        = IDX_W'(MATRIX_SIZE);

  streamer_state_t  r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_buf [NUM_EL];
  logic             r_overflow;

  logic             w_valid, w_fire, w_done, w_capture, w_drop;
  logic [IDX_W-1:0] w_src;
  logic [AW-1:0]    w_rd;

`ifdef RESULT_STREAM_CHECKSUM_EN
  logic [WIDTH-1:0] r_cksum, w_xor;

  always_comb begin
    w_xor = '0;
    for (int i = 0; i < NUM_EL; i++) w_xor ^= result[i];
  end
`endif

  // Beat k to source element. In column-major mode, walk down a column first.
  always_comb begin
    if (COL_MAJOR != 0) w_src = (r_cnt % MS) * MS + r_cnt / MS;
    else                w_src = r_cnt;
  end
  assign w_rd = w_src[AW-1:0];

  // Valid comes only from registered state, never from out_ready.
  assign w_valid = (r_state != IDLE);
  assign w_fire  = w_valid && m_out.out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_done          = 1'b0;
    w_capture       = 1'b0;
    w_drop          = 1'b0;
    m_out.out_valid = w_valid;
    m_out.out_data  = '0;
    m_out.out_index = '0;
    m_out.out_last  = 1'b0;

    case (r_state)
      STREAM: begin
        m_out.out_data  = r_buf[w_rd];
        m_out.out_index = w_src;
`ifndef RESULT_STREAM_CHECKSUM_EN
        m_out.out_last  = (r_cnt == LAST_BEAT);
`endif
        if (w_fire) begin
          if (r_cnt == LAST_BEAT) begin
`ifdef RESULT_STREAM_CHECKSUM_EN
            w_state_nxt = CKSUM;
`else
            w_done      = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`ifdef RESULT_STREAM_CHECKSUM_EN
      CKSUM: begin
        m_out.out_data  = r_cksum;
        m_out.out_index = IDX_W'(NUM_EL);
        m_out.out_last  = 1'b1;
        if (w_fire) w_done = 1'b1;
      end
`endif
      default: ;
    endcase

    if (w_done) w_state_nxt = IDLE;

    // A new matrix is taken when idle, or when the final beat leaves this
    // cycle. In that case the next stream starts with no extra bubble.
    if (result_ready) begin
      if (r_state == IDLE || w_done) begin
        w_capture   = 1'b1;
        w_state_nxt = STREAM;
        w_cnt_nxt   = '0;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // The set event has priority over clear_overflow.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  // The buffer has no reset, because its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      r_buf <= result;
`ifdef RESULT_STREAM_CHECKSUM_EN
      r_cksum <= w_xor;
`endif
    end
  end

  assign busy     = w_valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;
  import result_streamer_pkg::*;

`ifdef RESULT_STREAM_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NB = NUM_EL + CK;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [IDX_W-1:0] idx;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] result [NUM_EL];
  logic             rr_r, rr_c, clr;
  logic             busy_r, busy_c, ovf_r, ovf_c;
  logic             sel;
  logic             rdy;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t q[$];

  result_streamer_if s_r();
  result_streamer_if s_c();

  result_streamer #(.COL_MAJOR(0)) u_row (
    .clk(clk), .rst(rst), .result(result), .result_ready(rr_r),
    .clear_overflow(clr), .busy(busy_r), .overflow(ovf_r), .m_out(s_r.master));

  result_streamer #(.COL_MAJOR(1)) u_col (
    .clk(clk), .rst(rst), .result(result), .result_ready(rr_c),
    .clear_overflow(clr), .busy(busy_c), .overflow(ovf_c), .m_out(s_c.master));

  always #5 clk = ~clk;

  logic             w_valid, w_last, w_busy, w_ovf;
  logic [WIDTH-1:0] w_data;
  logic [IDX_W-1:0] w_idx;
  assign w_valid = sel ? s_c.out_valid : s_r.out_valid;
  assign w_last  = sel ? s_c.out_last  : s_r.out_last;
  assign w_data  = sel ? s_c.out_data  : s_r.out_data;
  assign w_idx   = sel ? s_c.out_index : s_r.out_index;
  assign w_busy  = sel ? busy_c : busy_r;
  assign w_ovf   = sel ? ovf_c  : ovf_r;

  // Loads result[i] = base+i and, if push is set, queues the expected beats.
  task automatic load(input int base, input bit push);
    logic [WIDTH-1:0] x;
    int src;
    x = '0;
    for (int i = 0; i < NUM_EL; i++) begin
      result[i] = WIDTH'(base + i);
      x ^= WIDTH'(base + i);
    end
    if (push) begin
      for (int k = 0; k < NUM_EL; k++) begin
        src = sel ? (k % MATRIX_SIZE) * MATRIX_SIZE + k / MATRIX_SIZE : k;
        q.push_back('{d: WIDTH'(base + src), idx: IDX_W'(src),
                      last: (k == NUM_EL-1) && (CK == 0)});
      end
      if (CK != 0) q.push_back('{d: x, idx: IDX_W'(NUM_EL), last: 1'b1});
    end
  endtask

  task automatic set_rr();
    if (sel) rr_c = 1'b1; else rr_r = 1'b1;
  endtask

  task automatic start(input int base);
    load(base, 1'b1);
    set_rr();
    @(negedge clk);
    rr_r = 1'b0; rr_c = 1'b0;
  endtask

  // Drains the current stream against the scoreboard. inj_kind: 0 none,
  // 1 dropped pulse (+clear in same cycle), 2 pulse on final beat, 3 reset.
  task automatic drain(input bit tog, input int inj_beat, input int inj_kind);
    beat_t e, held;
    int beat = 0, cyc = 0, first = -1, lastf = -1;
    bit stalled = 1'b0, chk_ovf = 1'b0;
    n_cmp++;
    if (w_valid !== 1'b1) begin
      n_err++; $display("FAIL latency: out_valid=%b want 1", w_valid);
    end
    forever begin
      if (q.size() == 0 && !w_valid) break;
      if (cyc >= 1000) begin
        n_cmp++; n_err++;
        $display("FAIL timeout: beats=%0d pending=%0d want 0", beat, q.size());
        break;
      end
      rdy = tog ? (cyc % 2 == 0) : 1'b1;
      s_r.out_ready = rdy; s_c.out_ready = rdy;
      if (stalled) begin
        n_cmp++;
        if (w_data !== held.d || w_idx !== held.idx || w_last !== held.last) begin
          n_err++;
          $display("FAIL hold: got %0d/%0d/%b want %0d/%0d/%b",
                   w_data, w_idx, w_last, held.d, held.idx, held.last);
        end
      end
      if (chk_ovf) begin
        n_cmp++; chk_ovf = 1'b0;
        if (w_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", w_ovf); end
      end
      if (inj_kind == 3 && beat == inj_beat && w_valid) begin
        rst = 1'b1;
        load(900, 1'b0);
        set_rr();
        q.delete();
        @(negedge clk);
        rst = 1'b0; rr_r = 1'b0; rr_c = 1'b0;
        n_cmp++;
        if (w_valid !== 1'b0 || w_idx !== '0 || w_data !== '0 || w_last !== 1'b0 || w_busy !== 1'b0) begin
          n_err++;
          $display("FAIL rst_abort: v=%b idx=%0d d=%0d l=%b busy=%b want all 0",
                   w_valid, w_idx, w_data, w_last, w_busy);
        end
        return;
      end
      if (w_valid && rdy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL extra_beat: idx=%0d want none", w_idx);
        end else begin
          e = q.pop_front();
          if (w_data !== e.d || w_idx !== e.idx || w_last !== e.last) begin
            n_err++;
            $display("FAIL beat%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b",
                     beat, w_data, w_idx, w_last, e.d, e.idx, e.last);
          end
        end
        if (beat == inj_beat && inj_kind == 1) begin
          load(7000, 1'b0); set_rr(); clr = 1'b1; chk_ovf = 1'b1;
        end
        if (beat == inj_beat && inj_kind == 2) begin
          load(5000, 1'b1); set_rr();
        end
        if (first < 0) first = cyc;
        lastf = cyc;
        beat++;
      end
      stalled = w_valid && !rdy;
      held = '{d: w_data, idx: w_idx, last: w_last};
      @(negedge clk);
      cyc++;
      rr_r = 1'b0; rr_c = 1'b0; clr = 1'b0;
    end
    if (inj_kind == 0) begin
      n_cmp++;
      if (lastf - first + 1 !== (tog ? 2*NB-1 : NB)) begin
        n_err++;
        $display("FAIL span: got %0d cycles want %0d", lastf - first + 1, tog ? 2*NB-1 : NB);
      end
    end
    n_cmp++;
    if (w_busy !== 1'b0) begin n_err++; $display("FAIL busy_end: got %b want 0", w_busy); end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      n_cmp++;
      if (w_valid !== 1'b0 || w_last !== 1'b0 || w_data !== '0 || w_idx !== '0 ||
          w_busy !== 1'b0 || w_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL reset%0d: v=%b l=%b d=%0d idx=%0d busy=%b ovf=%b want all 0",
                 s, w_valid, w_last, w_data, w_idx, w_busy, w_ovf);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_row_major();
    sel = 1'b0; start(1); drain(1'b0, -1, 0);
  endtask

  task automatic test_col_major();
    sel = 1'b1; start(1); drain(1'b0, -1, 0);
    sel = 1'b0;
  endtask

  task automatic test_stall();
    sel = 1'b0; start(1); drain(1'b1, -1, 0);
  endtask

  task automatic test_overflow();
    sel = 1'b0;
    n_cmp++;
    if (w_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_init: got %b want 0", w_ovf); end
    start(1); drain(1'b0, 10, 1);
    n_cmp++;
    if (w_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", w_ovf); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if (w_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", w_ovf); end
    start(1); drain(1'b0, NB-1, 2);
    n_cmp++;
    if (w_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_final_accept: got %b want 0", w_ovf); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; start(1); drain(1'b0, 20, 3);
    start(300); drain(1'b0, -1, 0);
  endtask

  task automatic test_checksum();
    sel = 1'b0; start(0); drain(1'b0, -1, 0);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; rr_r = 1'b0; rr_c = 1'b0; clr = 1'b0; rdy = 1'b0;
    s_r.out_ready = 1'b0; s_c.out_ready = 1'b0;
    for (int i = 0; i < NUM_EL; i++) result[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_row_major();
    test_col_major();
    test_stall();
    test_overflow();
    test_reset_mid();
    if (CK != 0) test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
